// File: rtl/eth_frame_deformer_if.sv
// AXI-Stream bundle shared by the RX input and the payload output of the deformer.
// Only the master side carries tuser (the length-error flag).
interface eth_frame_deformer_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;
  logic                  tuser;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                  input  tready);
  modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast,
                  output tready);
endinterface

// File: rtl/eth_frame_deformer.sv
// Strips the 16-byte link header from 64-bit RX frames, validates it against the
// configured addresses, forwards the payload and keeps saturating status counters.
module eth_frame_deformer #(
  parameter int DATA_WIDTH       = 64,
  parameter bit ACCEPT_BROADCAST = 1'b1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  eth_frame_deformer_if.slave  S_AXIS,
  eth_frame_deformer_if.master M_AXIS,
  input  logic [47:0]          Local_Address,
  input  logic [15:0]          Link_Type,
  input  logic [15:0]          SyncWord,
  input  logic [13:0]          Packet_Size,
  output logic [CNT_WIDTH-1:0] Frames_Ok,
  output logic [CNT_WIDTH-1:0] Frames_Dropped,
  output logic [CNT_WIDTH-1:0] Len_Errors,
  output logic [1:0]           DeformState
);

  typedef enum logic [1:0] {
    ST_HDR0    = 2'd0,
    ST_HDR1    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  dest_ok_q, dest_ok_d;
  logic [14:0]           byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [7:0]            m_keep_q, m_keep_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  m_user_q, m_user_d;
  logic [CNT_WIDTH-1:0]  cnt_ok_q, cnt_ok_d;
  logic [CNT_WIDTH-1:0]  cnt_drop_q, cnt_drop_d;
  logic [CNT_WIDTH-1:0]  cnt_len_q, cnt_len_d;

  logic                  s_ready_s;
  logic                  s_hs_s;
  logic [47:0]           rx_dest_s;
  logic [15:0]           rx_link_s;
  logic [15:0]           rx_sync_s;
  logic                  dest_match_s;
  logic                  keep_full_s;
  logic                  hdr_ok_s;
  logic [3:0]            beat_bytes_s;
  logic [14:0]           len_sum_s;
  logic                  len_err_s;

  function automatic logic [3:0] popcount8(input logic [7:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, k[i]};
    end
    return c;
  endfunction

  function automatic logic [14:0] sat_add15(input logic [14:0] base, input logic [3:0] inc);
    logic [15:0] sum;
    sum = {1'b0, base} + {12'd0, inc};
    return sum[15] ? 15'h7FFF : sum[14:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Header field extraction: first byte on the wire is the most significant.
  always_comb begin
    rx_dest_s    = {S_AXIS.tdata[7:0],   S_AXIS.tdata[15:8],  S_AXIS.tdata[23:16],
                    S_AXIS.tdata[31:24], S_AXIS.tdata[39:32], S_AXIS.tdata[47:40]};
    rx_link_s    = {S_AXIS.tdata[39:32], S_AXIS.tdata[47:40]};
    rx_sync_s    = {S_AXIS.tdata[55:48], S_AXIS.tdata[63:56]};
    keep_full_s  = (S_AXIS.tkeep == 8'hFF);
    dest_match_s = (rx_dest_s == Local_Address) ||
                   (ACCEPT_BROADCAST && (rx_dest_s == 48'hFFFF_FFFF_FFFF));
    hdr_ok_s     = dest_ok_q && keep_full_s &&
                   (rx_link_s == Link_Type) && (rx_sync_s == SyncWord);
    beat_bytes_s = popcount8(S_AXIS.tkeep);
    len_sum_s    = sat_add15(byte_cnt_q, beat_bytes_s);
    len_err_s    = (len_sum_s != {1'b0, Packet_Size});
  end

  // Next-state, output register and counter update logic.
  always_comb begin
    state_d    = state_q;
    dest_ok_d  = dest_ok_q;
    byte_cnt_d = byte_cnt_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    cnt_ok_d   = cnt_ok_q;
    cnt_drop_d = cnt_drop_q;
    cnt_len_d  = cnt_len_q;

    // Header and drop states never back-pressure, even with the output register full.
    if (ARESET) begin
      s_ready_s = 1'b0;
    end else if (state_q == ST_PAYLOAD) begin
      s_ready_s = !m_valid_q || M_AXIS.tready;
    end else begin
      s_ready_s = 1'b1;
    end
    s_hs_s = S_AXIS.tvalid && s_ready_s;

    if (m_valid_q && M_AXIS.tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    case (state_q)
      ST_HDR0: begin
        if (s_hs_s) begin
          dest_ok_d = dest_match_s && keep_full_s;
          if (S_AXIS.tlast) begin
            cnt_drop_d = sat_inc(cnt_drop_q);
          end else begin
            state_d = ST_HDR1;
          end
        end else begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR1: begin
        if (s_hs_s) begin
          if (S_AXIS.tlast) begin
            cnt_drop_d = sat_inc(cnt_drop_q);
            state_d    = ST_HDR0;
          end else if (hdr_ok_s) begin
            byte_cnt_d = 15'd0;
            state_d    = ST_PAYLOAD;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_HDR1;
        end
      end
      ST_PAYLOAD: begin
        if (s_hs_s) begin
          m_data_d   = S_AXIS.tdata;
          m_keep_d   = S_AXIS.tkeep;
          m_last_d   = S_AXIS.tlast;
          m_valid_d  = 1'b1;
          byte_cnt_d = len_sum_s;
          if (S_AXIS.tlast) begin
            m_user_d = len_err_s;
            cnt_ok_d = sat_inc(cnt_ok_q);
            if (len_err_s) begin
              cnt_len_d = sat_inc(cnt_len_q);
            end else begin
              cnt_len_d = cnt_len_q;
            end
            state_d = ST_HDR0;
          end else begin
            m_user_d = 1'b0;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (s_hs_s && S_AXIS.tlast) begin
          cnt_drop_d = sat_inc(cnt_drop_q);
          state_d    = ST_HDR0;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_HDR0;
      end
    endcase
  end

  // State, output register and counter flops with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_HDR0;
      dest_ok_q  <= 1'b0;
      byte_cnt_q <= 15'd0;
      m_data_q   <= {DATA_WIDTH{1'b0}};
      m_keep_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      cnt_ok_q   <= {CNT_WIDTH{1'b0}};
      cnt_drop_q <= {CNT_WIDTH{1'b0}};
      cnt_len_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      dest_ok_q  <= dest_ok_d;
      byte_cnt_q <= byte_cnt_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_drop_q <= cnt_drop_d;
      cnt_len_q  <= cnt_len_d;
    end
  end

  assign S_AXIS.tready  = s_ready_s;
  assign M_AXIS.tdata   = m_data_q;
  assign M_AXIS.tkeep   = m_keep_q;
  assign M_AXIS.tvalid  = m_valid_q;
  assign M_AXIS.tlast   = m_last_q;
  assign M_AXIS.tuser   = m_user_q;
  assign Frames_Ok      = cnt_ok_q;
  assign Frames_Dropped = cnt_drop_q;
  assign Len_Errors     = cnt_len_q;
  assign DeformState    = state_q;

endmodule

// File: tb/tb_eth_frame_deformer.sv
// Directed bench for eth_frame_deformer: header checks, length flag, stalls,
// runt and broadcast frames, and mid-frame reset.
module tb_eth_frame_deformer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [47:0] local_addr;
  logic [15:0] link_type;
  logic [15:0] sync_word;
  logic [13:0] packet_size;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;
  logic [15:0] len_errors;
  logic [1:0]  deform_state;

  int n_checks = 0;
  int n_fail   = 0;
  int m_beats  = 0;
  logic [63:0] cap_data[$];
  logic [7:0]  cap_keep[$];
  logic        cap_last[$];
  logic        cap_user[$];

  localparam logic [47:0] SRC = 48'h0A0B_0C0D_0E0F;
  localparam logic [63:0] P0  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] P1  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] P2  = 64'h9999_AAAA_BBBB_CCCC;

  eth_frame_deformer_if #(.DATA_WIDTH(64)) s_if ();
  eth_frame_deformer_if #(.DATA_WIDTH(64)) m_if ();

  eth_frame_deformer #(.DATA_WIDTH(64), .ACCEPT_BROADCAST(1'b1), .CNT_WIDTH(16)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS        (s_if.slave),
    .M_AXIS        (m_if.master),
    .Local_Address (local_addr),
    .Link_Type     (link_type),
    .SyncWord      (sync_word),
    .Packet_Size   (packet_size),
    .Frames_Ok     (frames_ok),
    .Frames_Dropped(frames_dropped),
    .Len_Errors    (len_errors),
    .DeformState   (deform_state)
  );

  always #5 ACLK = ~ACLK;

  // Output beat recorder, sampled away from the active edge.
  always @(negedge ACLK) begin
    if (m_if.tvalid && m_if.tready) begin
      cap_data.push_back(m_if.tdata);
      cap_keep.push_back(m_if.tkeep);
      cap_last.push_back(m_if.tlast);
      cap_user.push_back(m_if.tuser);
      m_beats++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr0(input logic [47:0] dst, input logic [47:0] src);
    logic [63:0] h;
    for (int i = 0; i < 6; i++) h[8*i +: 8] = dst[47-8*i -: 8];
    h[55:48] = src[47:40];
    h[63:56] = src[39:32];
    return h;
  endfunction

  function automatic logic [63:0] mk_hdr1(input logic [47:0] src, input logic [15:0] lt,
                                          input logic [15:0] sw);
    logic [63:0] h;
    for (int i = 0; i < 4; i++) h[8*i +: 8] = src[31-8*i -: 8];
    h[39:32] = lt[15:8];
    h[47:40] = lt[7:0];
    h[55:48] = sw[15:8];
    h[63:56] = sw[7:0];
    return h;
  endfunction

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Present one beat, wait (bounded) for the handshake, return 1 time unit after it.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int waited;
    waited = 0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(negedge ACLK);
    while (!s_if.tready && waited < 100) begin
      @(negedge ACLK);
      waited++;
    end
    if (!s_if.tready) check_val("send_ready_timeout", s_if.tready, 1);
    @(posedge ACLK);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_hdr(input logic [47:0] dst, input logic [15:0] lt, input logic [15:0] sw);
    send_beat(mk_hdr0(dst, SRC), 8'hFF, 1'b0);
    send_beat(mk_hdr1(SRC, lt, sw), 8'hFF, 1'b0);
  endtask

  initial begin
    int base;
    ARESET      = 1'b1;
    s_if.tdata  = 64'd0;
    s_if.tkeep  = 8'd0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
    local_addr  = 48'h0200_0000_0001;
    link_type   = 16'h88B5;
    sync_word   = 16'hA5A5;
    packet_size = 14'd24;

    // Reset state
    cyc();
    @(negedge ACLK);
    check_val("rst_s_tready", s_if.tready, 0);
    cyc();
    check_val("rst_m_tvalid", m_if.tvalid, 0);
    check_val("rst_m_tdata", m_if.tdata, 0);
    check_val("rst_counters", {frames_ok, frames_dropped, len_errors}, 0);
    check_val("rst_state", deform_state, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_val("post_rst_s_tready", s_if.tready, 1);
    cyc();

    // 1: good frame, 24-byte payload, one-cycle latency per beat
    send_hdr(48'h0200_0000_0001, 16'h88B5, 16'hA5A5);
    check_val("t1_state_payload", deform_state, 2);
    send_beat(P0, 8'hFF, 1'b0);
    check_val("t1_b0", {m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdata}, {1'b1, 8'hFF, 1'b0, P0});
    send_beat(P1, 8'hFF, 1'b0);
    check_val("t1_b1", {m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdata}, {1'b1, 8'hFF, 1'b0, P1});
    send_beat(P2, 8'hFF, 1'b1);
    check_val("t1_b2", {m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdata}, {1'b1, 8'hFF, 1'b1, P2});
    check_val("t1_tuser", m_if.tuser, 0);
    check_val("t1_frames_ok", frames_ok, 1);
    check_val("t1_state_hdr0", deform_state, 0);
    cyc();
    check_val("t1_drained", m_if.tvalid, 0);
    check_val("t1_beats", m_beats, 3);

    // 2: wrong sync word, frame discarded
    base = m_beats;
    send_hdr(48'h0200_0000_0001, 16'h88B5, 16'h1234);
    check_val("t2_state_drop", deform_state, 3);
    send_beat(P0, 8'hFF, 1'b0);
    send_beat(P1, 8'hFF, 1'b0);
    send_beat(P2, 8'hFF, 1'b1);
    cyc();
    check_val("t2_no_output", m_beats - base, 0);
    check_val("t2_dropped", frames_dropped, 1);
    check_val("t2_state_hdr0", deform_state, 0);

    // 3: 20-byte payload against Packet_Size 24
    base = m_beats;
    send_hdr(48'h0200_0000_0001, 16'h88B5, 16'hA5A5);
    send_beat(P0, 8'hFF, 1'b0);
    send_beat(P1, 8'hFF, 1'b0);
    send_beat(P2, 8'h0F, 1'b1);
    check_val("t3_last", {m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tuser}, {1'b1, 8'h0F, 1'b1, 1'b1});
    check_val("t3_len_errors", len_errors, 1);
    check_val("t3_frames_ok", frames_ok, 2);
    cyc();
    check_val("t3_beats", m_beats - base, 3);

    // 4: downstream stall pattern 1,0,0,1
    base = m_beats;
    send_hdr(48'h0200_0000_0001, 16'h88B5, 16'hA5A5);
    s_if.tdata = P0; s_if.tkeep = 8'hFF; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    @(negedge ACLK);
    check_val("t4_rdy_a", s_if.tready, 1);
    cyc();
    s_if.tdata = P1; m_if.tready = 1'b0;
    @(negedge ACLK);
    check_val("t4_rdy_b", s_if.tready, 0);
    check_val("t4_hold_b", m_if.tdata, P0);
    cyc();
    @(negedge ACLK);
    check_val("t4_rdy_c", s_if.tready, 0);
    check_val("t4_hold_c", {m_if.tvalid, m_if.tdata}, {1'b1, P0});
    cyc();
    m_if.tready = 1'b1;
    @(negedge ACLK);
    check_val("t4_rdy_d", s_if.tready, 1);
    cyc();
    s_if.tdata = P2; s_if.tlast = 1'b1;
    @(negedge ACLK);
    check_val("t4_no_bubble", {s_if.tready, m_if.tvalid, m_if.tdata}, {1'b1, 1'b1, P1});
    cyc();
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    cyc();
    check_val("t4_beats", m_beats - base, 3);
    check_val("t4_order0", cap_data[base], P0);
    check_val("t4_order1", cap_data[base+1], P1);
    check_val("t4_order2", {cap_data[base+2], cap_last[base+2], cap_user[base+2]}, {P2, 1'b1, 1'b0});
    check_val("t4_frames_ok", frames_ok, 3);

    // 5: runt then broadcast frame
    send_beat(mk_hdr0(48'h0200_0000_0001, SRC), 8'hFF, 1'b1);
    check_val("t5_runt_dropped", frames_dropped, 2);
    check_val("t5_runt_state", deform_state, 0);
    base = m_beats;
    send_hdr(48'hFFFF_FFFF_FFFF, 16'h88B5, 16'hA5A5);
    send_beat(P0, 8'hFF, 1'b0);
    send_beat(P1, 8'hFF, 1'b0);
    send_beat(P2, 8'hFF, 1'b1);
    cyc();
    check_val("t5_bcast_beats", m_beats - base, 3);
    check_val("t5_bcast_keep", cap_keep[base+2], 8'hFF);
    check_val("t5_counts", {frames_ok, frames_dropped}, {16'd4, 16'd2});

    // 6: reset mid-payload
    send_hdr(48'h0200_0000_0001, 16'h88B5, 16'hA5A5);
    m_if.tready = 1'b0;
    send_beat(P0, 8'hFF, 1'b0);
    check_val("t6_pre_valid", m_if.tvalid, 1);
    ARESET = 1'b1;
    cyc();
    ARESET = 1'b0;
    check_val("t6_valid", m_if.tvalid, 0);
    check_val("t6_counters", {frames_ok, frames_dropped, len_errors}, 0);
    check_val("t6_state", deform_state, 0);
    m_if.tready = 1'b1;
    send_beat(P1, 8'hFF, 1'b1);
    check_val("t6_leftover_dropped", frames_dropped, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/eth_frame_deformer.md
Name: eth_frame_deformer

Overview:
Receive-side counterpart of the transmit framer. Consumes 64-bit AXI-Stream Ethernet frames and strips the 16-byte header (destination, source, link type, sync word). It validates the header against the configured values and forwards only the payload downstream, with a length check against the expected packet size. It sits between the MAC RX stream and the user payload consumer, and keeps saturating status counters.

Parameters:
DATA_WIDTH, 64, stream width in bits; only 64 is supported (8 bytes per beat).
ACCEPT_BROADCAST, 1, when 1 also accept destination FF:FF:FF:FF:FF:FF.
CNT_WIDTH, 16, width of each status counter.

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous active-high reset
S_AXIS_tdata  in  64  input frame data; byte 0 = tdata[7:0] = first on wire
S_AXIS_tkeep  in  8  input byte enables
S_AXIS_tvalid  in  1  input valid
S_AXIS_tlast  in  1  last beat of frame
S_AXIS_tready  out  1  input ready
M_AXIS_tdata  out  64  payload data
M_AXIS_tkeep  out  8  payload byte enables
M_AXIS_tvalid  out  1  payload valid
M_AXIS_tlast  out  1  last payload beat
M_AXIS_tuser  out  1  length error flag, meaningful only on the tlast beat
M_AXIS_tready  in  1  downstream ready
Local_Address  in  48  expected destination MAC
Link_Type  in  16  expected EtherType
SyncWord  in  16  expected sync word
Packet_Size  in  14  expected payload bytes per frame
Frames_Ok  out  CNT_WIDTH  accepted frames counter
Frames_Dropped  out  CNT_WIDTH  header-mismatch plus runt frames counter
Len_Errors  out  CNT_WIDTH  accepted frames with a payload length mismatch
DeformState  out  2  current state, for debug

Behaviour:
- Header layout, most significant byte first on the wire:
  - Beat 0: bytes 0-5 = dest[47:0] (byte0 = dest[47:40]); bytes 6-7 = src[47:32].
  - Beat 1: bytes 0-3 = src[31:0]; bytes 4-5 = link type (byte4 = [15:8]); bytes 6-7 = sync word (byte6 = [15:8]).
- Source address is not checked.
- Config inputs are sampled on each header beat; changing them mid-frame affects only the remaining header checks.
- States, encoded HDR0=0, HDR1=1, PAYLOAD=2, DROP=3. Reset enters HDR0.
- Reset values: all counters 0; M_AXIS_tvalid/tlast/tuser 0; M_AXIS_tdata/tkeep 0; S_AXIS_tready 0 during reset, 1 on the first cycle after.
- HDR0: tready=1. On a handshake, latch dest_ok = (dest==Local_Address) or (ACCEPT_BROADCAST and dest==all-ones), and require tkeep==8'hFF.
  - tlast set: runt; increment Frames_Dropped; stay in HDR0.
  - Otherwise go to HDR1.
- HDR1: tready=1. On a handshake, evaluate ok = dest_ok, tkeep==FF, link==Link_Type, sync==SyncWord.
  - tlast set: runt (empty payload); increment Frames_Dropped; go to HDR0.
  - ok: go to PAYLOAD and clear byte_cnt.
  - Not ok: go to DROP.
- PAYLOAD: S_AXIS_tready = !M_AXIS_tvalid || M_AXIS_tready (single output register, no combinational valid path).
  - Each accepted beat loads the output register with tdata, tkeep and tlast, and adds popcount(tkeep) to byte_cnt (15-bit, saturating at 32767).
  - On the tlast beat, M_AXIS_tuser = ((byte_cnt + popcount) != Packet_Size); increment Frames_Ok; increment Len_Errors if tuser=1; go to HDR0.
- Payload latency: 1 cycle from S handshake to M_AXIS_tvalid.
- M_AXIS_tvalid stays high, with data stable, until M_AXIS_tready. It clears when the register drains and no new beat loads in the same cycle.
- DROP: tready=1; beats are discarded. On tlast, increment Frames_Dropped and go to HDR0.
- In HDR0, HDR1 and DROP the input is always ready, even while the output register still holds the previous frame's last beat.
- Counters saturate at all-ones and never wrap.
- Reset mid-frame: state returns to HDR0, the output register is cleared, and counters are zeroed. Remaining input beats of the interrupted frame are parsed as a new header, which is expected to be dropped.
- A simultaneous output drain and input load in PAYLOAD is full throughput: one beat per cycle, no bubble.

Test Plan:
1. Frame with dest=Local_Address=02:00:00:00:00:01, Link_Type=0x88B5, SyncWord=0xA5A5, 24-byte payload, Packet_Size=24, M_AXIS_tready=1 -> 3 payload beats out, tkeep FF,FF,FF, tlast on the third beat, tuser=0, Frames_Ok=1, each beat 1 cycle after its input.
2. Same frame but SyncWord in the frame = 0x1234 -> no M_AXIS_tvalid; all beats accepted; Frames_Dropped=1 after tlast; state returns to HDR0.
3. Payload of 20 bytes (last tkeep=0x0F) with Packet_Size=24 -> tlast beat carries tkeep=0x0F and tuser=1; Len_Errors=1; Frames_Ok=1.
4. M_AXIS_tready toggles 1,0,0,1 during the payload -> no beat lost or duplicated; M_AXIS_tdata stable while stalled; S_AXIS_tready low exactly while the register is full and not draining.
5. One-beat frame (tlast in HDR0), then a broadcast-dest frame with ACCEPT_BROADCAST=1 -> Frames_Dropped=1, the second frame is forwarded, Frames_Ok=1.
6. ARESET asserted for 1 cycle mid-payload -> next cycle M_AXIS_tvalid=0, all counters 0, DeformState=0.
